iir_param_loader: RTL and testbench

- Front-end stage that feeds the first-order IIR datapath.
- Captures input samples into a registered x stream.
- Holds the active coefficient set (b0, b1, a, offset) and exposes it to the filter.
- Accepts coefficient writes into a shadow bank, then swaps the whole set atomically on a sample boundary, so the filter never computes with a mixed old/new set.

---
 rtl/iir_pkg.sv | 43 ++++
 rtl/iir_coef_bank.sv | 44 ++++
 rtl/iir_param_loader.sv | 122 ++++++++++++
 tb/tb_iir_param_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared types and word-format constants for the first-order IIR front end.
// Coefficient words are sign-magnitude Q15.16.
package iir_pkg;

  localparam int N_BITS   = 32;
  localparam int SIGN_BIT = 31;
  localparam int INT_MSB  = 30;
  localparam int INT_LSB  = 16;
  localparam int FRAC_MSB = 15;

  typedef enum logic [1:0] {
    ADDR_B0     = 2'd0,
    ADDR_B1     = 2'd1,
    ADDR_A      = 2'd2,
    ADDR_OFFSET = 2'd3
  } coef_addr_t;

  typedef enum logic [1:0] {
    CLEAN   = 2'd0,
    DIRTY   = 2'd1,
    PENDING = 2'd2
  } loader_state_t;

  typedef struct packed {
    logic [N_BITS-1:0] b0;
    logic [N_BITS-1:0] b1;
    logic [N_BITS-1:0] a;
    logic [N_BITS-1:0] offset;
  } coef_set_t;

  // Builds a Q15.16 sign-magnitude word from its three fields.
  function automatic logic [N_BITS-1:0] q_word(input logic sgn,
                                               input logic [INT_MSB-INT_LSB:0] int_mag,
                                               input logic [FRAC_MSB:0] frac_mag);
    logic [N_BITS-1:0] w;
    w                   = '0;
    w[SIGN_BIT]         = sgn;
    w[INT_MSB:INT_LSB]  = int_mag;
    w[FRAC_MSB:0]       = frac_mag;
    return w;
  endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Resettable four-word coefficient bank: single-word addressed writes, or a
// whole-set load that takes priority over a write in the same cycle.
module iir_coef_bank
  import iir_pkg::*;
#(
  parameter logic [N_BITS-1:0] B0_RST     = 32'h0001_0000,
  parameter logic [N_BITS-1:0] B1_RST     = 32'h0000_0000,
  parameter logic [N_BITS-1:0] A_RST      = 32'h0000_0000,
  parameter logic [N_BITS-1:0] OFFSET_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [1:0]        wr_addr_i,
  input  logic [N_BITS-1:0] wr_data_i,
  input  logic              load_en_i,
  input  coef_set_t         load_set_i,
  output coef_set_t         set_o
);

  coef_set_t set_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q.b0     <= B0_RST;
      set_q.b1     <= B1_RST;
      set_q.a      <= A_RST;
      set_q.offset <= OFFSET_RST;
    end else if (load_en_i) begin
      set_q <= load_set_i;
    end else if (wr_en_i) begin
      case (coef_addr_t'(wr_addr_i))
        ADDR_B0:     set_q.b0     <= wr_data_i;
        ADDR_B1:     set_q.b1     <= wr_data_i;
        ADDR_A:      set_q.a      <= wr_data_i;
        ADDR_OFFSET: set_q.offset <= wr_data_i;
        default:     set_q        <= set_q;
      endcase
    end
  end

  assign set_o = set_q;

endmodule

// File: rtl/iir_param_loader.sv
// IIR front end: registers input samples and swaps a shadow coefficient set
// into the active set atomically on the first sample after a commit request.
module iir_param_loader
  import iir_pkg::*;
#(
  parameter logic [31:0] B0_RST     = 32'h0001_0000,
  parameter logic [31:0] B1_RST     = 32'h0000_0000,
  parameter logic [31:0] A_RST      = 32'h0000_0000,
  parameter logic [31:0] OFFSET_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [1:0]        wr_addr_i,
  input  logic [N_BITS-1:0] wr_data_i,
  input  logic              commit_i,
  input  logic              sample_valid_i,
  input  logic [N_BITS-1:0] sample_i,
  output logic [N_BITS-1:0] x_o,
  output logic              x_valid_o,
  output logic [N_BITS-1:0] b0_o,
  output logic [N_BITS-1:0] b1_o,
  output logic [N_BITS-1:0] a_o,
  output logic [N_BITS-1:0] offset_o,
  output logic              busy_o,
  output logic              commit_done_o,
  output logic [1:0]        dbg_state_o
);

  // Write handshake: a word transfers on a rising edge where wr_valid_i and
  // wr_ready_o are both high; wr_valid_i may be held while wr_ready_o is low.
  loader_state_t     state_q, state_d;
  logic              write_fire;
  logic              commit_apply;
  logic              commit_done_d, commit_done_q;
  logic [N_BITS-1:0] x_q;
  logic              x_valid_q;
  coef_set_t         shadow_set, active_set;

  assign wr_ready_o   = (state_q != PENDING);
  assign write_fire   = wr_valid_i & wr_ready_o;
  assign commit_apply = (state_q == PENDING) & sample_valid_i;

  always_comb begin
    state_d       = state_q;
    commit_done_d = 1'b0;
    case (state_q)
      CLEAN: begin
        if (write_fire && commit_i) begin
          state_d = PENDING;
        end else if (write_fire) begin
          state_d = DIRTY;
        end else if (commit_i) begin
          commit_done_d = 1'b1;
        end
      end
      DIRTY: begin
        if (commit_i) state_d = PENDING;
      end
      PENDING: begin
        if (sample_valid_i) begin
          state_d       = CLEAN;
          commit_done_d = 1'b1;
        end
      end
      default: state_d = CLEAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= CLEAN;
      commit_done_q <= 1'b0;
      x_q           <= '0;
      x_valid_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_done_q <= commit_done_d;
      x_valid_q     <= sample_valid_i;
      if (sample_valid_i) x_q <= sample_i;
    end
  end

  iir_coef_bank #(
    .B0_RST(B0_RST), .B1_RST(B1_RST), .A_RST(A_RST), .OFFSET_RST(OFFSET_RST)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en_i   (write_fire),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .load_en_i (1'b0),
    .load_set_i(active_set),
    .set_o     (shadow_set)
  );

  // Shadow is frozen while PENDING, so the loaded set is exactly what was committed.
  iir_coef_bank #(
    .B0_RST(B0_RST), .B1_RST(B1_RST), .A_RST(A_RST), .OFFSET_RST(OFFSET_RST)
  ) u_active (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en_i   (1'b0),
    .wr_addr_i (2'd0),
    .wr_data_i ('0),
    .load_en_i (commit_apply),
    .load_set_i(shadow_set),
    .set_o     (active_set)
  );

  assign x_o           = x_q;
  assign x_valid_o     = x_valid_q;
  assign b0_o          = active_set.b0;
  assign b1_o          = active_set.b1;
  assign a_o           = active_set.a;
  assign offset_o      = active_set.offset;
  assign busy_o        = (state_q == PENDING);
  assign commit_done_o = commit_done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_iir_param_loader.sv
// Self-checking bench for iir_param_loader: directed scenario tasks plus a
// scoreboard that checks {x, b0, b1, a, offset} on every x_valid_o pulse.
module tb_iir_param_loader;
  import iir_pkg::*;

  localparam int EW = 5 * N_BITS;

  logic              clk;
  logic              reset;
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [1:0]        wr_addr_i;
  logic [N_BITS-1:0] wr_data_i;
  logic              commit_i;
  logic              sample_valid_i;
  logic [N_BITS-1:0] sample_i;
  logic [N_BITS-1:0] x_o;
  logic              x_valid_o;
  logic [N_BITS-1:0] b0_o, b1_o, a_o, offset_o;
  logic              busy_o;
  logic              commit_done_o;
  logic [1:0]        dbg_state_o;

  int compared   = 0;
  int mismatched = 0;
  logic [EW-1:0] exp_q[$];

  iir_param_loader dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .commit_i      (commit_i),
    .sample_valid_i(sample_valid_i),
    .sample_i      (sample_i),
    .x_o           (x_o),
    .x_valid_o     (x_valid_o),
    .b0_o          (b0_o),
    .b1_o          (b1_o),
    .a_o           (a_o),
    .offset_o      (offset_o),
    .busy_o        (busy_o),
    .commit_done_o (commit_done_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset && x_valid_o) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard_underflow: x_valid_o with x=%h but nothing expected", x_o);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({x_o, b0_o, b1_o, a_o, offset_o} !== e) begin
          mismatched++;
          $display("FAIL scoreboard_sample: got x=%h b0=%h b1=%h a=%h off=%h, expected x=%h b0=%h b1=%h a=%h off=%h",
                   x_o, b0_o, b1_o, a_o, offset_o,
                   e[159:128], e[127:96], e[95:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wr_valid_i     = 1'b0;
    wr_addr_i      = 2'd0;
    wr_data_i      = '0;
    commit_i       = 1'b0;
    sample_valid_i = 1'b0;
    sample_i       = '0;
  endtask

  task automatic set_write(input logic [1:0] addr, input logic [N_BITS-1:0] data);
    wr_valid_i = 1'b1;
    wr_addr_i  = addr;
    wr_data_i  = data;
  endtask

  task automatic set_sample(input logic [N_BITS-1:0] s, input logic [N_BITS-1:0] eb0,
                            input logic [N_BITS-1:0] eb1, input logic [N_BITS-1:0] ea,
                            input logic [N_BITS-1:0] eoff);
    sample_valid_i = 1'b1;
    sample_i       = s;
    exp_q.push_back({s, eb0, eb1, ea, eoff});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    compared += 7;
    if (b0_o !== 32'h0001_0000) begin mismatched++; $display("FAIL reset_b0: got %h expected 00010000", b0_o); end
    if (b1_o !== 32'h0) begin mismatched++; $display("FAIL reset_b1: got %h expected 0", b1_o); end
    if (a_o !== 32'h0) begin mismatched++; $display("FAIL reset_a: got %h expected 0", a_o); end
    if (offset_o !== 32'h0) begin mismatched++; $display("FAIL reset_offset: got %h expected 0", offset_o); end
    if (x_o !== 32'h0) begin mismatched++; $display("FAIL reset_x: got %h expected 0", x_o); end
    if (busy_o !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    if (wr_ready_o !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", wr_ready_o); end
  endtask

  task automatic test_commit_apply();
    set_write(2'd0, 32'h0000_8000); tick();
    set_write(2'd2, 32'h8000_4000); tick();
    drive_idle(); commit_i = 1'b1; tick();
    commit_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compared += 2;
      if (b0_o !== 32'h0001_0000 || a_o !== 32'h0) begin
        mismatched++; $display("FAIL apply_hold_active: got b0=%h a=%h expected 00010000/0", b0_o, a_o);
      end
      if (busy_o !== 1'b1) begin mismatched++; $display("FAIL apply_busy: got %b expected 1", busy_o); end
      tick();
    end
    set_sample(32'h0002_0000, 32'h0000_8000, 32'h0, 32'h8000_4000, 32'h0);
    tick();
    drive_idle();
    compared += 4;
    if (b0_o !== 32'h0000_8000 || a_o !== 32'h8000_4000) begin
      mismatched++; $display("FAIL apply_active: got b0=%h a=%h expected 00008000/80004000", b0_o, a_o);
    end
    if (x_o !== 32'h0002_0000 || x_valid_o !== 1'b1) begin
      mismatched++; $display("FAIL apply_x: got x=%h v=%b expected 00020000/1", x_o, x_valid_o);
    end
    if (commit_done_o !== 1'b1) begin mismatched++; $display("FAIL apply_done: got %b expected 1", commit_done_o); end
    if (busy_o !== 1'b0) begin mismatched++; $display("FAIL apply_busy_clear: got %b expected 0", busy_o); end
    tick();
    compared++;
    if (commit_done_o !== 1'b0) begin mismatched++; $display("FAIL apply_done_once: got %b expected 0", commit_done_o); end
  endtask

  task automatic test_stall();
    set_write(2'd3, 32'h0000_0005); commit_i = 1'b1; tick();
    commit_i = 1'b0;
    set_write(2'd1, 32'h0000_1000); tick();
    compared += 2;
    if (wr_ready_o !== 1'b0) begin mismatched++; $display("FAIL stall_ready: got %b expected 0", wr_ready_o); end
    if (busy_o !== 1'b1) begin mismatched++; $display("FAIL stall_busy: got %b expected 1", busy_o); end
    set_sample(32'h0000_0011, 32'h0000_8000, 32'h0, 32'h8000_4000, 32'h5);
    tick();
    sample_valid_i = 1'b0;
    compared += 3;
    if (offset_o !== 32'h5 || b1_o !== 32'h0) begin
      mismatched++; $display("FAIL stall_commit: got off=%h b1=%h expected 5/0", offset_o, b1_o);
    end
    if (commit_done_o !== 1'b1) begin mismatched++; $display("FAIL stall_done: got %b expected 1", commit_done_o); end
    if (wr_ready_o !== 1'b1) begin mismatched++; $display("FAIL stall_ready_back: got %b expected 1", wr_ready_o); end
    tick();
    drive_idle();
    compared += 2;
    if (b1_o !== 32'h0) begin mismatched++; $display("FAIL stall_b1_held: got %h expected 0", b1_o); end
    if (dbg_state_o !== DIRTY) begin mismatched++; $display("FAIL stall_dirty: got %0d expected %0d", dbg_state_o, DIRTY); end
    commit_i = 1'b1; tick();
    commit_i = 1'b0;
    set_sample(32'h0000_0022, 32'h0000_8000, 32'h0000_1000, 32'h8000_4000, 32'h5);
    tick();
    drive_idle();
    compared++;
    if (b1_o !== 32'h0000_1000) begin mismatched++; $display("FAIL stall_b1_applied: got %h expected 00001000", b1_o); end
  endtask

  task automatic test_same_cycle();
    set_write(2'd0, 32'h0003_0000);
    commit_i = 1'b1;
    set_sample(32'h7, 32'h0000_8000, 32'h0000_1000, 32'h8000_4000, 32'h5);
    tick();
    drive_idle();
    compared += 2;
    if (busy_o !== 1'b1) begin mismatched++; $display("FAIL same_busy: got %b expected 1", busy_o); end
    if (b0_o !== 32'h0000_8000) begin mismatched++; $display("FAIL same_old_b0: got %h expected 00008000", b0_o); end
    tick();
    set_sample(32'h9, 32'h0003_0000, 32'h0000_1000, 32'h8000_4000, 32'h5);
    tick();
    drive_idle();
    compared += 2;
    if (b0_o !== 32'h0003_0000) begin mismatched++; $display("FAIL same_new_b0: got %h expected 00030000", b0_o); end
    if (commit_done_o !== 1'b1) begin mismatched++; $display("FAIL same_done: got %b expected 1", commit_done_o); end
    tick();
  endtask

  task automatic test_noop_commit();
    commit_i = 1'b1; tick();
    commit_i = 1'b0;
    compared += 3;
    if (commit_done_o !== 1'b1) begin mismatched++; $display("FAIL noop_done: got %b expected 1", commit_done_o); end
    if (busy_o !== 1'b0) begin mismatched++; $display("FAIL noop_busy: got %b expected 0", busy_o); end
    if (b0_o !== 32'h0003_0000) begin mismatched++; $display("FAIL noop_active: got %h expected 00030000", b0_o); end
    tick();
    compared++;
    if (commit_done_o !== 1'b0) begin mismatched++; $display("FAIL noop_done_once: got %b expected 0", commit_done_o); end
  endtask

  task automatic test_commit_in_pending();
    set_write(2'd2, 32'h0); commit_i = 1'b1; tick();
    wr_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      compared += 2;
      if (commit_done_o !== 1'b0) begin mismatched++; $display("FAIL pend_no_done: got %b expected 0", commit_done_o); end
      if (busy_o !== 1'b1) begin mismatched++; $display("FAIL pend_busy: got %b expected 1", busy_o); end
    end
    commit_i = 1'b0;
    set_sample(32'h0000_00AB, 32'h0003_0000, 32'h0000_1000, 32'h0, 32'h5);
    tick();
    drive_idle();
    compared++;
    if (commit_done_o !== 1'b1) begin mismatched++; $display("FAIL pend_done: got %b expected 1", commit_done_o); end
    tick();
    compared++;
    if (commit_done_o !== 1'b0) begin mismatched++; $display("FAIL pend_done_once: got %b expected 0", commit_done_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      set_sample($urandom_range(32'h7FFF_FFFF, 0), 32'h0003_0000, 32'h0000_1000, 32'h0, 32'h5);
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_pending();
    set_write(2'd0, 32'h0000_1234); commit_i = 1'b1; tick();
    drive_idle();
    compared++;
    if (busy_o !== 1'b1) begin mismatched++; $display("FAIL rstp_busy_before: got %b expected 1", busy_o); end
    reset = 1'b0;
    #1;
    compared += 4;
    if (busy_o !== 1'b0) begin mismatched++; $display("FAIL rstp_busy: got %b expected 0", busy_o); end
    if (b0_o !== 32'h0001_0000 || b1_o !== 32'h0 || a_o !== 32'h0 || offset_o !== 32'h0) begin
      mismatched++; $display("FAIL rstp_active: got b0=%h b1=%h a=%h off=%h expected 00010000/0/0/0", b0_o, b1_o, a_o, offset_o);
    end
    if (x_o !== 32'h0) begin mismatched++; $display("FAIL rstp_x: got %h expected 0", x_o); end
    if (wr_ready_o !== 1'b1) begin mismatched++; $display("FAIL rstp_ready: got %b expected 1", wr_ready_o); end
    tick();
    reset = 1'b1;
    tick();
    set_sample(32'h55, 32'h0001_0000, 32'h0, 32'h0, 32'h0);
    tick();
    drive_idle();
    compared += 2;
    if (commit_done_o !== 1'b0) begin mismatched++; $display("FAIL rstp_no_done: got %b expected 0", commit_done_o); end
    if (b0_o !== 32'h0001_0000) begin mismatched++; $display("FAIL rstp_no_apply: got %h expected 00010000", b0_o); end
    set_write(2'd1, 32'h0000_0777); commit_i = 1'b1; tick();
    drive_idle();
    set_sample(32'h66, 32'h0001_0000, 32'h0000_0777, 32'h0, 32'h0);
    tick();
    drive_idle();
    compared++;
    if (b0_o !== q_word(1'b0, 15'd1, 16'd0)) begin
      mismatched++; $display("FAIL rstp_shadow_reset: got b0=%h expected 00010000", b0_o);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_commit_apply();
    test_stall();
    test_same_cycle();
    test_noop_commit();
    test_commit_in_pending();
    test_back_to_back();
    test_reset_pending();
    repeat (3) tick();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++; $display("FAIL scoreboard_leftover: %0d samples never produced, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
